// File: rtl/nn_frame_classifier.sv
// nn_frame_classifier
//   Loads a binary image as NUM_ROWS rows of ROW_BITS bits, scores it against
//   NUM_CLASSES binary templates (one class per cycle, score = number of
//   matching bits), and holds the best-matching class until acknowledged.
//
// State table
//   state   | meaning
//   LOAD    | accepting image rows (row_ready high)
//   SCORE   | scoring class cls_cnt against the stored image (busy high)
//   HOLD    | presenting class_out/class_score (result_valid high)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   row_in       image row data
//   row_valid    row_in valid
//   row_ready    block accepts a row this cycle
//   frame_abort  discard current frame/result and restart loading
//   templates    class c at bits [c*IMG_BITS +: IMG_BITS]; stable while busy
//   result_valid class_out/class_score valid
//   result_ack   consumer accepts result
//   class_out    winning class index
//   class_score  winning score, 0..IMG_BITS
//   busy         high while scoring
//   frame_count  results acknowledged, wraps to 0
module nn_frame_classifier #(
    parameter  int ROW_BITS    = 7,
    parameter  int NUM_ROWS    = 28,
    parameter  int NUM_CLASSES = 10,
    parameter  int CLASS_W     = 4,
    parameter  int FCNT_W      = 8,
    localparam int IMG_BITS    = ROW_BITS * NUM_ROWS,
    localparam int SCORE_W     = $clog2(IMG_BITS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ROW_BITS-1:0]             row_in,
    input  logic                            row_valid,
    output logic                            row_ready,
    input  logic                            frame_abort,
    input  logic [NUM_CLASSES*IMG_BITS-1:0] templates,
    output logic                            result_valid,
    input  logic                            result_ack,
    output logic [CLASS_W-1:0]              class_out,
    output logic [SCORE_W-1:0]              class_score,
    output logic                            busy,
    output logic [FCNT_W-1:0]               frame_count
);

    localparam int RC_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [RC_W-1:0]    LAST_ROW = RC_W'(NUM_ROWS - 1);
    localparam logic [CLASS_W-1:0] LAST_CLS = CLASS_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SCORE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [RC_W-1:0]     row_cnt;
    logic [CLASS_W-1:0]  cls_cnt;
    logic [IMG_BITS-1:0] image;
    logic [CLASS_W-1:0]  best_cls;
    logic [SCORE_W-1:0]  best_score;

    logic [IMG_BITS-1:0] tpl_sel;
    logic [IMG_BITS-1:0] match_bits;
    logic [SCORE_W-1:0]  cur_score;
    logic                take_cur;
    logic [CLASS_W-1:0]  fin_cls;
    logic [SCORE_W-1:0]  fin_score;
    logic                row_accept;

    // row_ready is also forced low while rst is asserted so no row can be
    // handshaken on the reset edge.
    assign row_ready    = (state == S_LOAD) && !rst;
    assign busy         = (state == S_SCORE);
    assign result_valid = (state == S_HOLD);

    assign row_accept = (state == S_LOAD) && row_valid && !frame_abort;

    // Matching-bit count of the stored image against the current template.
    always_comb begin
        tpl_sel    = templates[int'(cls_cnt)*IMG_BITS +: IMG_BITS];
        match_bits = ~(image ^ tpl_sel);
        cur_score  = '0;
        for (int i = 0; i < IMG_BITS; i++) begin
            cur_score = cur_score + SCORE_W'(match_bits[i]);
        end
    end

    // Strict greater-than keeps the lower index on ties; class 0 always seeds.
    always_comb begin
        take_cur  = (cls_cnt == '0) || (cur_score > best_score);
        fin_cls   = take_cur ? cls_cnt   : best_cls;
        fin_score = take_cur ? cur_score : best_score;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_LOAD: begin
                if (row_accept && (row_cnt == LAST_ROW)) begin
                    state_next = S_SCORE;
                end
            end
            S_SCORE: begin
                if (cls_cnt == LAST_CLS) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (result_ack) begin
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_LOAD;
        endcase
        if (frame_abort) begin
            state_next = S_LOAD;
        end
    end

    // Image buffer has no reset; every row is rewritten before it is scored.
    always_ff @(posedge clk) begin
        if (!rst && row_accept) begin
            image[int'(row_cnt)*ROW_BITS +: ROW_BITS] <= row_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt     <= '0;
            cls_cnt     <= '0;
            best_cls    <= '0;
            best_score  <= '0;
            class_out   <= '0;
            class_score <= '0;
            frame_count <= '0;
        end else if (frame_abort) begin
            row_cnt <= '0;
            cls_cnt <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (row_valid) begin
                        if (row_cnt == LAST_ROW) begin
                            row_cnt    <= '0;
                            cls_cnt    <= '0;
                            best_cls   <= '0;
                            best_score <= '0;
                        end else begin
                            row_cnt <= row_cnt + RC_W'(1);
                        end
                    end
                end
                S_SCORE: begin
                    best_cls   <= fin_cls;
                    best_score <= fin_score;
                    if (cls_cnt == LAST_CLS) begin
                        class_out   <= fin_cls;
                        class_score <= fin_score;
                        cls_cnt     <= '0;
                    end else begin
                        cls_cnt <= cls_cnt + CLASS_W'(1);
                    end
                end
                S_HOLD: begin
                    if (result_ack) begin
                        frame_count <= frame_count + FCNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_frame_classifier.sv
module tb_nn_frame_classifier;

    localparam int ROW_BITS    = 7;
    localparam int NUM_ROWS    = 28;
    localparam int NUM_CLASSES = 10;
    localparam int CLASS_W     = 4;
    localparam int FCNT_W      = 8;
    localparam int IMG_BITS    = ROW_BITS * NUM_ROWS;
    localparam int SCORE_W     = $clog2(IMG_BITS + 1);

    logic                            clk = 1'b0;
    logic                            rst;
    logic [ROW_BITS-1:0]             row_in;
    logic                            row_valid;
    logic                            row_ready;
    logic                            frame_abort;
    logic [NUM_CLASSES*IMG_BITS-1:0] templates;
    logic                            result_valid;
    logic                            result_ack;
    logic [CLASS_W-1:0]              class_out;
    logic [SCORE_W-1:0]              class_score;
    logic                            busy;
    logic [FCNT_W-1:0]               frame_count;

    int n_total = 0;
    int n_bad   = 0;

    nn_frame_classifier #(
        .ROW_BITS(ROW_BITS), .NUM_ROWS(NUM_ROWS), .NUM_CLASSES(NUM_CLASSES),
        .CLASS_W(CLASS_W), .FCNT_W(FCNT_W)
    ) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .row_valid(row_valid),
        .row_ready(row_ready), .frame_abort(frame_abort), .templates(templates),
        .result_valid(result_valid), .result_ack(result_ack),
        .class_out(class_out), .class_score(class_score), .busy(busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit                m_live = 0;
    int                m_rows = 0;
    bit [IMG_BITS-1:0] m_img;
    int                m_left = -1;   // edges remaining until result; -1 = not scoring
    bit                m_hold = 0;
    int                p_cls, p_score;
    int                e_cls = 0, e_score = 0, e_fc = 0;

    function automatic void argmax(input bit [IMG_BITS-1:0] img, output int bc, output int bs);
        bit [IMG_BITS-1:0] t;
        int s;
        bs = -1;
        bc = 0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            t = templates[c*IMG_BITS +: IMG_BITS];
            s = $countones(~(img ^ t));
            if (s > bs) begin
                bs = s;
                bc = c;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1;
            m_rows = 0; m_left = -1; m_hold = 0;
            e_cls = 0; e_score = 0; e_fc = 0;
        end else if (m_live) begin
            if (frame_abort) begin
                m_rows = 0; m_left = -1; m_hold = 0;
            end else if (m_hold) begin
                if (result_ack) begin
                    m_hold = 0;
                    e_fc = (e_fc + 1) % (1 << FCNT_W);
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_left = -1;
                    m_hold = 1;
                    e_cls = p_cls;
                    e_score = p_score;
                end
            end else if (row_valid) begin
                m_img[m_rows*ROW_BITS +: ROW_BITS] = row_in;
                m_rows++;
                if (m_rows == NUM_ROWS) begin
                    m_rows = 0;
                    argmax(m_img, p_cls, p_score);
                    m_left = NUM_CLASSES;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("row_ready", row_ready, (!m_hold && m_left < 0 && !rst));
            chk("busy", busy, (m_left > 0));
            chk("result_valid", result_valid, m_hold);
            chk("class_out", class_out, e_cls);
            chk("class_score", class_score, e_score);
            chk("frame_count", frame_count, e_fc);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic bit [IMG_BITS-1:0] rand_img();
        bit [IMG_BITS-1:0] v;
        for (int i = 0; i < IMG_BITS; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic set_t1_templates();
        templates = '0;
        templates[3*IMG_BITS +: IMG_BITS] = {IMG_BITS{1'b1}};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends nrows rows; returns #1 after the edge accepting the last one.
    task automatic send_rows(input bit [IMG_BITS-1:0] img, input int maxgap, input int nrows);
        int  tries;
        bit  ok;
        for (int r = 0; r < nrows; r++) begin
            row_valid = 1'b0;
            repeat ($urandom_range(0, maxgap)) tick();
            row_valid = 1'b1;
            row_in = img[r*ROW_BITS +: ROW_BITS];
            tries = 0;
            ok = 0;
            while (!ok && tries < 100) begin
                @(negedge clk);
                ok = row_ready;
                tick();
                tries++;
            end
            if (!ok) chk("row_accept_timeout", 0, 1);
        end
        row_valid = 1'b0;
    endtask

    task automatic wait_result(output int edges);
        edges = 0;
        while (!result_valid && edges < 100) begin
            tick();
            edges++;
        end
        if (!result_valid) chk("result_timeout", 0, 1);
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit [IMG_BITS-1:0] ones, img;
        int lat, r_cls, r_sc, fc0;

        ones = {IMG_BITS{1'b1}};
        rst = 1'b1; row_in = '0; row_valid = 1'b0; frame_abort = 1'b0;
        result_ack = 1'b0; templates = '0;
        repeat (3) tick();
        chk("reset_class_out", class_out, 0);
        chk("reset_frame_count", frame_count, 0);
        chk("reset_row_ready_low", row_ready, 0);
        rst = 1'b0;
        #1;
        chk("row_ready_after_release", row_ready, 1);

        // T1
        set_t1_templates();
        send_rows(ones, 0, NUM_ROWS);
        wait_result(lat);
        chk("t1_latency", lat, 10);
        chk("t1_class", class_out, 3);
        chk("t1_score", class_score, 196);
        do_ack();
        chk("t1_frame_count", frame_count, 1);

        // T2
        for (int i = 0; i < IMG_BITS; i++)
            for (int c = 0; c < NUM_CLASSES; c++)
                templates[c*IMG_BITS + i] = (i % 2 == 0);
        send_rows(ones, 0, NUM_ROWS);
        wait_result(lat);
        chk("t2_class", class_out, 0);
        chk("t2_score", class_score, 98);
        do_ack();
        send_rows(rand_img(), 1, NUM_ROWS);
        wait_result(lat);
        chk("t2_rand_class", class_out, 0);
        do_ack();

        // T3
        for (int i = 0; i < NUM_CLASSES*IMG_BITS; i++) templates[i] = 1'($urandom_range(0, 1));
        img = rand_img();
        send_rows(img, 0, NUM_ROWS);
        wait_result(lat);
        r_cls = class_out;
        r_sc = class_score;
        row_valid = 1'b1;
        repeat (5) begin
            row_in = 7'($urandom);
            tick();
        end
        row_valid = 1'b0;
        do_ack();
        send_rows(img, 3, NUM_ROWS);
        wait_result(lat);
        chk("t3_gap_class", class_out, r_cls);
        chk("t3_gap_score", class_score, r_sc);
        do_ack();

        // T4
        set_t1_templates();
        fc0 = frame_count;
        send_rows('0, 1, 15);
        frame_abort = 1'b1;
        row_valid = 1'b1;
        tick();
        frame_abort = 1'b0;
        row_valid = 1'b0;
        chk("t4_fc_after_abort", frame_count, fc0);
        send_rows(ones, 0, NUM_ROWS);
        wait_result(lat);
        chk("t4_class", class_out, 3);
        chk("t4_score", class_score, 196);
        chk("t4_fc_before_ack", frame_count, fc0);
        frame_abort = 1'b1;
        result_ack = 1'b1;
        tick();
        frame_abort = 1'b0;
        result_ack = 1'b0;
        chk("t4_abort_beats_ack", frame_count, fc0);

        // T5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int f = 0; f < 257; f++) begin
            send_rows(rand_img(), 0, NUM_ROWS);
            wait_result(lat);
            do_ack();
        end
        chk("t5_wrap", frame_count, 1);
        result_ack = 1'b1;
        repeat (3) tick();
        result_ack = 1'b0;
        chk("t5_ack_in_load", frame_count, 1);

        // T6
        set_t1_templates();
        send_rows(ones, 0, NUM_ROWS);
        repeat (5) tick();
        chk("t6_busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        chk("t6_class", class_out, 0);
        chk("t6_score", class_score, 0);
        chk("t6_busy", busy, 0);
        chk("t6_valid", result_valid, 0);
        chk("t6_fc", frame_count, 0);
        chk("t6_ready_in_rst", row_ready, 0);
        rst = 1'b0;
        #1;
        chk("t6_ready_release", row_ready, 1);
        send_rows(ones, 2, NUM_ROWS);
        wait_result(lat);
        chk("t6_latency", lat, 10);
        chk("t6_after_class", class_out, 3);
        chk("t6_after_score", class_score, 196);
        do_ack();
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
